// File: rtl/run_sequencer.sv
// Run-level controller: holds the core in reset, releases it, counts run cycles until
// core_done or the watchdog fires, then reports until the host drops req.
module run_sequencer #(
  parameter int          RST_CYC = 2,
  parameter int          CW      = 16,
  parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          core_done,
  output logic          core_reset,
  output logic          core_run,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int              HW        = $clog2(RST_CYC) + 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_CYC - 1);
  localparam logic [CW-1:0]   RUN_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   RUN_LIMIT = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_FIN,
    S_FAULT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_nxt;
  logic [CW-1:0] cycles_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      cycles   <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      cycles   <= cycles_nxt;
    end
  end

  // Dropping req aborts a run in progress; in FIN/FAULT it is the only way back to IDLE.
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    cycles_nxt = cycles;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt  = S_HOLD;
          hold_nxt   = '0;
          cycles_nxt = '0;
        end
      end
      S_HOLD: begin
        if (!req) begin
          state_nxt = S_IDLE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = S_RUN;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!req) begin
          state_nxt = S_IDLE;
        end else if (core_done) begin
          state_nxt  = S_FIN;
          cycles_nxt = cycles + 1'b1;
        end else if (cycles == RUN_LAST) begin
          state_nxt  = S_FAULT;
          cycles_nxt = RUN_LIMIT;
        end else begin
          cycles_nxt = cycles + 1'b1;
        end
      end
      S_FIN, S_FAULT: begin
        if (!req) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decode the state register only, so an async reset shows up immediately.
  assign core_reset = (state == S_IDLE) || (state == S_HOLD);
  assign core_run   = (state == S_RUN);
  assign done       = (state == S_FIN) || (state == S_FAULT);
  assign timeout    = (state == S_FAULT);

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: reset checks, a vector table, directed corner sequences and
// randomized req/core_done traffic against a behavioural run model.
module tb_run_sequencer;

  localparam int          RST_CYC = 2;
  localparam int          CW      = 16;
  localparam int unsigned TIMEOUT = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          core_done;
  logic          core_reset;
  logic          core_run;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycles;

  run_sequencer #(
    .RST_CYC (RST_CYC),
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .core_done  (core_done),
    .core_reset (core_reset),
    .core_run   (core_run),
    .done       (done),
    .timeout    (timeout),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: a run is either idle, busy (holding then running) or over.
  bit m_busy;
  bit m_over;
  bit m_fault;
  int m_hold_left;
  int m_cycles;

  function automatic void model_reset();
    m_busy      = 1'b0;
    m_over      = 1'b0;
    m_fault     = 1'b0;
    m_hold_left = 0;
    m_cycles    = 0;
  endfunction

  function automatic void model_edge(bit r, bit cd);
    if (m_over) begin
      if (!r) m_over = 1'b0;
    end else if (!m_busy) begin
      if (r) begin
        m_busy      = 1'b1;
        m_hold_left = RST_CYC;
        m_cycles    = 0;
      end
    end else if (!r) begin
      m_busy = 1'b0;
    end else if (m_hold_left > 0) begin
      m_hold_left = m_hold_left - 1;
    end else begin
      m_cycles = m_cycles + 1;
      if (cd) begin
        m_busy  = 1'b0;
        m_over  = 1'b1;
        m_fault = 1'b0;
      end else if (m_cycles == int'(TIMEOUT)) begin
        m_busy  = 1'b0;
        m_over  = 1'b1;
        m_fault = 1'b1;
      end
    end
  endfunction

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    bit e_run;
    e_run = m_busy && (m_hold_left == 0);
    check1({tag, ".core_reset"}, 32'(core_reset), 32'(!m_over && !e_run));
    check1({tag, ".core_run"},   32'(core_run),   32'(e_run));
    check1({tag, ".done"},       32'(done),       32'(m_over));
    check1({tag, ".timeout"},    32'(timeout),    32'(m_over && m_fault));
    check1({tag, ".cycles"},     32'(cycles),     32'(m_cycles));
  endtask

  // Apply inputs, take one rising edge, then compare 1 time unit later.
  task automatic step(input bit r, input bit cd, input string tag);
    req       = r;
    core_done = cd;
    @(posedge clk);
    model_edge(r, cd);
    #1;
    check_model(tag);
  endtask

  task automatic go_idle();
    step(1'b0, 1'b0, "idle");
    step(1'b0, 1'b0, "idle");
  endtask

  // From IDLE: two HOLD cycles, then the edge into RUN.
  task automatic enter_run(input string tag);
    step(1'b1, 1'b0, tag);
    check1({tag, ".hold1_core_reset"}, 32'(core_reset), 32'd1);
    step(1'b1, 1'b0, tag);
    check1({tag, ".hold2_core_reset"}, 32'(core_reset), 32'd1);
    step(1'b1, 1'b0, tag);
    check1({tag, ".run_core_reset"}, 32'(core_reset), 32'd0);
    check1({tag, ".run_core_run"},   32'(core_run),   32'd1);
  endtask

  typedef struct {
    bit r;
    bit cd;
    bit e_cr;
    bit e_run;
    bit e_done;
    bit e_to;
    int e_cyc;
  } vec_t;

  vec_t vecs[17];

  initial begin
    reset     = 1'b0;
    req       = 1'b0;
    core_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check1("rst.core_reset", 32'(core_reset), 32'd1);
    check1("rst.core_run",   32'(core_run),   32'd0);
    check1("rst.done",       32'(done),       32'd0);
    check1("rst.timeout",    32'(timeout),    32'd0);
    check1("rst.cycles",     32'(cycles),     32'd0);
    @(negedge clk);
    reset = 1'b1;

    // req cd | core_reset core_run done timeout cycles
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};

    for (int i = 0; i < 17; i++) begin
      req       = vecs[i].r;
      core_done = vecs[i].cd;
      @(posedge clk);
      model_edge(vecs[i].r, vecs[i].cd);
      #1;
      check1($sformatf("vec%0d.core_reset", i), 32'(core_reset), 32'(vecs[i].e_cr));
      check1($sformatf("vec%0d.core_run", i),   32'(core_run),   32'(vecs[i].e_run));
      check1($sformatf("vec%0d.done", i),       32'(done),       32'(vecs[i].e_done));
      check1($sformatf("vec%0d.timeout", i),    32'(timeout),    32'(vecs[i].e_to));
      check1($sformatf("vec%0d.cycles", i),     32'(cycles),     32'(vecs[i].e_cyc));
    end

    // Normal completion on the 30th RUN edge, then req release.
    go_idle();
    enter_run("t2");
    for (int i = 0; i < 29; i++) step(1'b1, 1'b0, "t2");
    step(1'b1, 1'b1, "t2");
    check1("t2.done",    32'(done),    32'd1);
    check1("t2.timeout", 32'(timeout), 32'd0);
    check1("t2.cycles",  32'(cycles),  32'd30);
    step(1'b0, 1'b0, "t2");
    check1("t2.done_fall", 32'(done), 32'd0);

    // Watchdog: core_done never arrives.
    go_idle();
    enter_run("t3");
    for (int i = 0; i < 99; i++) step(1'b1, 1'b0, "t3");
    check1("t3.done_early", 32'(done),   32'd0);
    check1("t3.cycles99",   32'(cycles), 32'd99);
    step(1'b1, 1'b0, "t3");
    check1("t3.done",    32'(done),    32'd1);
    check1("t3.timeout", 32'(timeout), 32'd1);
    check1("t3.cycles",  32'(cycles),  32'd100);
    check1("t3.core_reset", 32'(core_reset), 32'd0);

    // core_done on the same edge the watchdog would fire: completion wins.
    go_idle();
    enter_run("t4");
    for (int i = 0; i < 99; i++) step(1'b1, 1'b0, "t4");
    step(1'b1, 1'b1, "t4");
    check1("t4.done",    32'(done),    32'd1);
    check1("t4.timeout", 32'(timeout), 32'd0);
    check1("t4.cycles",  32'(cycles),  32'd100);

    // Abort after 10 RUN edges.
    go_idle();
    enter_run("t5");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "t5");
    step(1'b0, 1'b0, "t5");
    check1("t5.core_reset", 32'(core_reset), 32'd1);
    check1("t5.done",       32'(done),       32'd0);
    check1("t5.cycles",     32'(cycles),     32'd10);
    step(1'b0, 1'b0, "t5");
    check1("t5.done_after", 32'(done), 32'd0);

    // req held through FIN: no restart until req has been low for an edge.
    go_idle();
    enter_run("t6");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "t6");
    step(1'b1, 1'b1, "t6");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "t6");
    check1("t6.done_held",   32'(done),   32'd1);
    check1("t6.cycles_held", 32'(cycles), 32'd5);
    step(1'b0, 1'b0, "t6");
    step(1'b1, 1'b0, "t6");
    check1("t6.rehold_core_reset", 32'(core_reset), 32'd1);
    check1("t6.rehold_cycles",     32'(cycles),     32'd0);

    // Async reset in RUN with cycles=5.
    go_idle();
    enter_run("t1");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "t1");
    check1("t1.cycles_before", 32'(cycles), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check1("t1.core_reset", 32'(core_reset), 32'd1);
    check1("t1.done",       32'(done),       32'd0);
    check1("t1.cycles",     32'(cycles),     32'd0);
    check1("t1.core_run",   32'(core_run),   32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, "t1_post");

    // Randomized traffic: req toggles rarely so some runs reach the watchdog.
    begin
      bit r_lvl;
      r_lvl = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 59) == 0) r_lvl = ~r_lvl;
        step(r_lvl, ($urandom_range(0, 79) == 0), "rnd");
        if ($urandom_range(0, 499) == 0) begin
          #2;
          reset = 1'b0;
          #1;
          model_reset();
          check_model("rnd_rst");
          @(negedge clk);
          reset = 1'b1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
